// File: rtl/ibex_bloom_ctrl.sv
// Bloom-filter command sequencer for the EX-stage custom ops: hashes the key,
// walks the word-organised bit array through insert, check or clear sequences.
module ibex_bloom_ctrl #(
    parameter int unsigned NumHashes = 3,
    parameter int unsigned IdxWidth  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [1:0]            op_i,
    input  logic [31:0]           key_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic                  result_o,
    output logic [15:0]           count_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [IdxWidth-6:0]   mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [31:0]           mem_wmask_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam int unsigned AddrWidth = IdxWidth - 5;
    localparam int unsigned CntWidth  = 6;
    localparam logic [CntWidth-1:0] LastProbe = CntWidth'(NumHashes - 1);
    localparam logic [CntWidth-1:0] LastWord  = CntWidth'((1 << AddrWidth) - 1);

    typedef enum logic [1:0] {
        OpNop    = 2'b00,
        OpInsert = 2'b01,
        OpCheck  = 2'b10,
        OpClear  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StInsert,
        StCheck,
        StCheckWait,
        StClear,
        StDone
    } state_e;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [IdxWidth-1:0]   h2_q, h2_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  hit_q, hit_d;
    logic [4:0]            cur_bit_q, cur_bit_d;
    logic [4:0]            prev_bit_q;
    logic [15:0]           count_q, count_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [AddrWidth-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           mem_wmask_q, mem_wmask_d;

    logic                  accept;
    logic [IdxWidth-1:0]   key_h1, key_h2;
    logic [IdxWidth-1:0]   probe_idx;
    logic                  probe_en, probe_we;
    logic                  unused_key;

    assign key_h1     = key_i[IdxWidth-1:0] ^ key_i[2*IdxWidth-1:IdxWidth];
    assign key_h2     = key_i[3*IdxWidth-1:2*IdxWidth] | IdxWidth'(1);
    assign unused_key = ^key_i[31:3*IdxWidth];
    assign accept     = en_i & ready_o;

    // NOTE: every flop, including the registered memory outputs, is cleared by
    // the asynchronous reset; sequential state uses non-blocking assignments.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            op_q        <= OpNop;
            idx_q       <= '0;
            h2_q        <= '0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            cur_bit_q   <= '0;
            prev_bit_q  <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            h2_q        <= h2_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            cur_bit_q   <= cur_bit_d;
            prev_bit_q  <= cur_bit_q;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
        end
    end

    // NOTE: next-state is fully defaulted before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    unique case (op_e'(op_i))
                        OpNop:    state_d = StDone;
                        OpInsert: state_d = StInsert;
                        OpCheck:  state_d = StCheck;
                        OpClear:  state_d = StClear;
                        default:  state_d = StIdle;
                    endcase
                end
            end
            StInsert:    if (cnt_q == LastProbe) state_d = StDone;
            StCheck:     if (cnt_q == LastProbe) state_d = StCheckWait;
            StCheckWait: state_d = StDone;
            StClear:     if (cnt_q == LastWord) state_d = StDone;
            default:     state_d = StIdle;
        endcase
    end

    // Memory outputs are registered, so the access for the next cycle is
    // computed here from the current state and loaded at the same edge.
    always_comb begin
        op_d        = op_q;
        idx_d       = idx_q;
        h2_d        = h2_q;
        cnt_d       = cnt_q;
        hit_d       = hit_q;
        cur_bit_d   = '0;
        count_d     = count_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wmask_d = '0;
        probe_idx   = idx_q;
        probe_en    = 1'b0;
        probe_we    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    op_d      = op_e'(op_i);
                    h2_d      = key_h2;
                    cnt_d     = '0;
                    hit_d     = 1'b1;
                    probe_idx = key_h1;
                    unique case (op_e'(op_i))
                        OpInsert: begin
                            probe_en = 1'b1;
                            probe_we = 1'b1;
                        end
                        OpCheck: probe_en = 1'b1;
                        OpClear: begin
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_wmask_d = '1;
                        end
                        default: ;
                    endcase
                end
            end
            StInsert: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != LastProbe) begin
                    probe_en = 1'b1;
                    probe_we = 1'b1;
                end else if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            StCheck: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != '0) hit_d = hit_q & mem_rdata_i[prev_bit_q];
                if (cnt_q != LastProbe) probe_en = 1'b1;
            end
            StCheckWait: hit_d = hit_q & mem_rdata_i[prev_bit_q];
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != LastWord) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = AddrWidth'(cnt_q + 1'b1);
                    mem_wmask_d = '1;
                end else begin
                    count_d = '0;
                end
            end
            default: ;
        endcase

        if (probe_en) begin
            mem_req_d  = 1'b1;
            mem_we_d   = probe_we;
            mem_addr_d = probe_idx[IdxWidth-1:5];
            cur_bit_d  = probe_idx[4:0];
            idx_d      = probe_idx + h2_d;
            if (probe_we) begin
                mem_wdata_d = 32'd1 << probe_idx[4:0];
                mem_wmask_d = 32'd1 << probe_idx[4:0];
            end
        end
    end

    always_comb begin
        ready_o  = (state_q == StIdle) || (state_q == StDone);
        valid_o  = (state_q == StDone);
        result_o = (state_q == StDone) && (op_q == OpCheck) && hit_q;
    end

    assign count_o     = count_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;

endmodule

// File: doc/ibex_bloom_ctrl.md
# ibex_bloom_ctrl

Sequencer for the EX-stage bloom-filter custom instructions. It accepts one INSERT, CHECK or CLEAR command at a time and computes the NumHashes bit indices from the 32-bit key. It drives a single-port, word-organised bit-array memory through the required write, read or sweep sequence, then returns a one-cycle valid pulse with the membership result. It sits between the ID/EX custom-op decode and the filter storage, and replaces ad-hoc per-op enables with a single valid/ready handshake.

## Interface
- NumHashes, default 3: hash probes per key; legal range 1..8.
- IdxWidth, default 10: the filter holds 2^IdxWidth bits in 2^(IdxWidth-5) words of 32 bits; legal range 6..10.
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- en_i  in  1  command request; held until accepted.
- op_i  in  2  command: 00 NOP, 01 INSERT, 10 CHECK, 11 CLEAR.
- key_i  in  32  key (custom RS1 operand).
- ready_o  out  1  command can be accepted this cycle.
- valid_o  out  1  one-cycle completion pulse.
- result_o  out  1  CHECK hit; 0 for all other ops; meaningful only with valid_o.
- count_o  out  16  saturating count of INSERTs since the last CLEAR or reset.
- mem_req_o  out  1  memory access this cycle.
- mem_we_o  out  1  write (1) or read (0).
- mem_addr_o  out  IdxWidth-5  word address.
- mem_wdata_o  out  32  write data.
- mem_wmask_o  out  32  per-bit write enable.
- mem_rdata_i  in  32  read data, valid exactly one cycle after a read request; memory is always granted.

## Operation
- Hashing, computed at acceptance:
  - h1 = key[IdxWidth-1:0] ^ key[2*IdxWidth-1:IdxWidth].
  - h2 = key[3*IdxWidth-1:2*IdxWidth] with bit 0 forced to 1.
  - idx_i = (h1 + i*h2) mod 2^IdxWidth for i = 0..NumHashes-1.
  - Generated iteratively with an accumulator (idx += h2, wrap-around by truncation). No multiplier.
- Bit mapping: word = idx[IdxWidth-1:5], bit = idx[4:0].
- Handshake: a command is accepted when en_i & ready_o at a clock edge. op_i and key_i are sampled only then. en_i is ignored while ready_o is low.
- FSM states: IDLE, INSERT, CHECK, CHECK_WAIT, CLEAR, DONE.
  - IDLE or DONE, on accept: NOP goes to DONE. INSERT, CHECK and CLEAR go to the state of the same name.
  - IDLE or DONE, without accept: go to IDLE.
  - INSERT: one write per cycle; mem_wdata_o = mem_wmask_o = 1<<bit. After NumHashes writes, go to DONE.
  - CHECK: one read per cycle. The hit accumulator starts at 1 and ANDs in each returned bit. After NumHashes reads, go to CHECK_WAIT.
  - CHECK_WAIT: no memory access; AND in the last returned bit, then go to DONE.
  - CLEAR: write words 0..2^(IdxWidth-5)-1 in ascending order with wdata 0 and wmask all-ones, then go to DONE.
  - DONE: valid_o = 1. result_o = hit for CHECK, else 0.
- count_o:
  - Increments in the DONE cycle of an INSERT and saturates at 16'hFFFF.
  - Zeroed in the DONE cycle of a CLEAR.
  - NOP and CHECK leave it unchanged.
- Duplicate or colliding indices within one key are not merged; each probe is still performed.

## Timing
- Reset values: state IDLE, ready_o 1, valid_o 0, result_o 0, count_o 0, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, mem_wmask_o 0.
- ready_o = 1 in IDLE and DONE only, so back-to-back commands are accepted in a DONE cycle.
- Latency, with the command accepted at edge T:
  - NOP: valid_o at T+1.
  - INSERT: writes in T+1..T+NumHashes; valid_o at T+NumHashes+1.
  - CHECK: reads in T+1..T+NumHashes; valid_o at T+NumHashes+2.
  - CLEAR: writes in T+1..T+W, where W = 2^(IdxWidth-5); valid_o at T+W+1.
- Memory outputs are registered. mem_req_o is high only in INSERT, CHECK and CLEAR states; all other memory outputs are 0 when mem_req_o is low.
- Reset mid-operation: outputs go to reset values immediately (asynchronously) and any partial sequence is abandoned. Memory contents are not cleared; software must issue CLEAR.
- Timing is data-independent: there is no early exit on a CHECK miss.

## Test plan
- Reset, then INSERT key 0x0000_0000 with NumHashes 3, accepted at T. Required: writes at T+1..T+3 to word 0 with masks 0x1, 0x2, 0x4; valid_o at T+4; count_o = 1.
- INSERT key 0x0030_0C05 (h1 = 6, h2 = 3), then CHECK the same key. Required: insert writes word 0 with masks 0x40, 0x200, 0x1000; CHECK reads word 0 three times, gives valid_o at T+5 with result_o = 1.
- CLEAR with IdxWidth 10, then CHECK 0x0030_0C05. Required: 32 writes to words 0..31 with wmask 0xFFFF_FFFF and wdata 0; valid_o at T+33; count_o = 0; the CHECK returns result_o = 0.
- Hold en_i with INSERT during a CHECK. Required: ready_o stays low and the INSERT is not accepted until the CHECK's DONE cycle. Its first write occurs the cycle after DONE.
- Assert rst_i during the second write of an INSERT. Required: mem_req_o falls at once; state returns to IDLE; count_o = 0; no valid_o pulse.
- Issue 65536 INSERTs. Required: count_o saturates at 0xFFFF. A NOP then returns valid_o at T+1 with result_o = 0 and count_o unchanged.
